uart_rx_cfg: RTL and testbench

Runtime-configurable UART receiver, the next generation of the fixed-format receiver.
- Data length is configurable up to MAX_DATA bits; parity can be none, even or odd; stop bits can be 1 or 2.
- Each bit is decided by a 3-sample majority vote; errors are flagged per frame.
- Output is a valid/ready word interface with overrun reporting.
- Sits between the baud tick generator and the RX FIFO / decoder input stage.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sampler.sv | 62 ++++++
 rtl/uart_rx_cfg.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
// Imported by the sampler and the receiver top.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } par_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    WAIT_IDLE
  } rx_state_t;

  localparam int MIN_DATA_BITS = 5;

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, oversample tick counter and 3-sample majority vote.
// The detecting tick counts as index 0 of the start bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVER_SAMPLE = 16,
  parameter int MID_SAMPLE  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_rx_serial,
  input  logic restart,
  output logic line,
  output logic bit_value,
  output logic bit_strobe,
  output logic bit_end
);

  localparam int CW = $clog2(OVER_SAMPLE);
  localparam logic [CW-1:0] C_LO   = CW'(MID_SAMPLE - 1);
  localparam logic [CW-1:0] C_MID  = CW'(MID_SAMPLE);
  localparam logic [CW-1:0] C_HI   = CW'(MID_SAMPLE + 1);
  localparam logic [CW-1:0] C_LAST = CW'(OVER_SAMPLE - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s0;
  logic                   s1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_rx_serial};
    end
  end

  assign line = sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
      s0  <= 1'b1;
      s1  <= 1'b1;
    end else if (i_tick) begin
      if (restart) begin
        cnt <= CW'(1);
      end else begin
        cnt <= (cnt == C_LAST) ? '0 : cnt + 1'b1;
        if (cnt == C_LO)  s0 <= line;
        if (cnt == C_MID) s1 <= line;
      end
    end
  end

  assign bit_value  = (s0 & s1) | (s0 & line) | (s1 & line);
  assign bit_strobe = i_tick && !restart && (cnt == C_HI);
  assign bit_end    = i_tick && !restart && (cnt == C_LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: data length, parity and stop bits
// latched per frame, valid/ready word output with overrun pulse.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int MAX_DATA    = 9,
  parameter int OVER_SAMPLE = 16,
  parameter int MID_SAMPLE  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_tick,
  input  logic                         i_rx_en,
  input  logic                         i_rx_serial,
  input  logic [$clog2(MAX_DATA+1)-1:0] i_cfg_data_bits,
  input  logic [1:0]                   i_cfg_parity,
  input  logic                         i_cfg_stop2,
  output logic [MAX_DATA-1:0]          o_rx_data,
  output logic                         o_rx_valid,
  input  logic                         i_rx_ready,
  output logic                         o_parity_err,
  output logic                         o_frame_err,
  output logic                         o_overrun,
  output logic                         o_busy
);

  localparam int BW = $clog2(MAX_DATA + 1);
  typedef logic [BW-1:0] bits_t;
  localparam bits_t MIN_B = bits_t'(MIN_DATA_BITS);
  localparam bits_t MAX_B = bits_t'(MAX_DATA);

  function automatic bits_t clamp_bits(bits_t b);
    if (b < MIN_B) return MIN_B;
    if (b > MAX_B) return MAX_B;
    return b;
  endfunction

  function automatic par_t dec_par(logic [1:0] p);
    case (p)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  rx_state_t             state;
  bits_t                 bits_q;
  bits_t                 idx;
  par_t                  par_q;
  logic                  stop2_q;
  logic [MAX_DATA-1:0]   shift_q;
  logic                  acc_q;
  logic                  perr_q;
  logic                  ferr_q;

  logic      line;
  logic      bit_value;
  logic      bit_strobe;
  logic      bit_end;
  logic      start_det;
  logic      last_stop;
  logic      done;
  logic      frm_ferr;
  rx_state_t next_after;

  assign start_det = i_tick && (state == IDLE) && i_rx_en && !line;

  uart_rx_sampler #(
    .OVER_SAMPLE(OVER_SAMPLE),
    .MID_SAMPLE (MID_SAMPLE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_tick     (i_tick),
    .i_rx_serial(i_rx_serial),
    .restart    (start_det),
    .line       (line),
    .bit_value  (bit_value),
    .bit_strobe (bit_strobe),
    .bit_end    (bit_end)
  );

  assign last_stop  = ((state == STOP1) && !stop2_q) || (state == STOP2);
  assign done       = bit_strobe && last_stop;
  assign frm_ferr   = ferr_q | ~bit_value;
  // An all-zero frame with a bad stop is a break: hold until the line rises
  assign next_after = (frm_ferr && shift_q == '0) ? WAIT_IDLE : IDLE;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      bits_q  <= '0;
      idx     <= '0;
      par_q   <= PAR_NONE;
      stop2_q <= 1'b0;
      shift_q <= '0;
      acc_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else if (i_tick) begin
      unique case (state)
        IDLE: begin
          if (start_det) begin
            state   <= START;
            bits_q  <= clamp_bits(i_cfg_data_bits);
            par_q   <= dec_par(i_cfg_parity);
            stop2_q <= i_cfg_stop2;
            idx     <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
          end
        end
        START: begin
          if (bit_strobe && bit_value) state <= IDLE;
          else if (bit_end)            state <= DATA;
        end
        DATA: begin
          if (bit_strobe) begin
            for (int i = 0; i < MAX_DATA; i++) begin
              if (idx == bits_t'(i)) shift_q[i] <= bit_value;
            end
            acc_q <= acc_q ^ bit_value;
            idx   <= idx + 1'b1;
          end
          if (bit_end && idx == bits_q) begin
            state <= (par_q == PAR_NONE) ? STOP1 : PARITY;
          end
        end
        PARITY: begin
          if (bit_strobe &&
              bit_value != (acc_q ^ (par_q == PAR_ODD))) begin
            perr_q <= 1'b1;
          end
          if (bit_end) state <= STOP1;
        end
        STOP1: begin
          if (bit_strobe) begin
            if (!bit_value) ferr_q <= 1'b1;
            if (!stop2_q)   state  <= next_after;
          end else if (bit_end && stop2_q) begin
            state <= STOP2;
          end
        end
        STOP2: begin
          if (bit_strobe) state <= next_after;
        end
        WAIT_IDLE: begin
          if (line) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (done) begin
        if (!o_rx_valid || i_rx_ready) begin
          o_rx_data    <= shift_q;
          o_rx_valid   <= 1'b1;
          o_parity_err <= perr_q;
          o_frame_err  <= frm_ferr;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_rx_valid && i_rx_ready) begin
        o_rx_valid   <= 1'b0;
        o_parity_err <= 1'b0;
        o_frame_err  <= 1'b0;
      end
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: directed frames, queue of expected
// words, separate monitor checking each accepted word.
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx_en = 1'b1;
  logic       rx = 1'b1;
  logic [3:0] cfg_bits = 4'd8;
  logic [1:0] cfg_par = 2'd0;
  logic       cfg_stop2 = 1'b0;
  logic [8:0] data;
  logic       valid;
  logic       ready = 1'b1;
  logic       perr;
  logic       ferr;
  logic       ovr;
  logic       busy;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_miss = 0;
  int   valid_cyc = 0;
  int   ovr_cnt = 0;
  int   div = 0;
  int   v0;
  int   o0;
  int   bt;

  uart_rx_cfg dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_tick         (tick),
    .i_rx_en        (rx_en),
    .i_rx_serial    (rx),
    .i_cfg_data_bits(cfg_bits),
    .i_cfg_parity   (cfg_par),
    .i_cfg_stop2    (cfg_stop2),
    .o_rx_data      (data),
    .o_rx_valid     (valid),
    .i_rx_ready     (ready),
    .o_parity_err   (perr),
    .o_frame_err    (ferr),
    .o_overrun      (ovr),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks
  initial begin
    forever begin
      @(negedge clk);
      tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (valid) valid_cyc++;
    if (ovr) ovr_cnt++;
    if (valid && ready) begin
      n_vec++;
      if (q.size() == 0) begin
        n_miss++;
        $display("FAIL word: unexpected data=%h pe=%b fe=%b",
                 data, perr, ferr);
      end else begin
        e = q.pop_front();
        if ({data, perr, ferr} !== {e.d, e.pe, e.fe}) begin
          n_miss++;
          $display("FAIL word: got data=%h pe=%b fe=%b want data=%h pe=%b fe=%b",
                   data, perr, ferr, e.d, e.pe, e.fe);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (!tick);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (16) wait_tick();
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * 16) wait_tick();
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb,
                            input int pbit, input logic s1,
                            input logic s2, input int nstop);
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    if (pbit >= 0) send_bit(pbit[0]);
    send_bit(s1);
    if (nstop == 2) send_bit(s2);
    rx = 1'b1;
  endtask

  task automatic set_cfg(input logic [3:0] b, input logic [1:0] p,
                         input logic s2);
    cfg_bits  = b;
    cfg_par   = p;
    cfg_stop2 = s2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({data, valid, perr, ferr, ovr, busy}), 0);
    rst_n = 1'b1;
    idle(2);

    // 8N1 0xA5
    set_cfg(4'd8, 2'd0, 1'b0);
    v0 = valid_cyc;
    q.push_back('{9'h0A5, 1'b0, 1'b0});
    send_frame(9'h0A5, 8, -1, 1'b1, 1'b1, 1);
    idle(2);
    chk("t1_valid_width", valid_cyc - v0, 1);

    // 7E1 0x35, parity bit forced to 1 (correct even parity is 0)
    set_cfg(4'd7, 2'd1, 1'b0);
    q.push_back('{9'h035, 1'b1, 1'b0});
    send_frame(9'h035, 7, 1, 1'b1, 1'b1, 1);
    idle(2);

    // 9O1 0x1FF, nine ones so correct odd parity bit is 0
    set_cfg(4'd9, 2'd2, 1'b0);
    q.push_back('{9'h1FF, 1'b0, 1'b0});
    send_frame(9'h1FF, 9, 0, 1'b1, 1'b1, 1);
    idle(2);

    // 4-tick low glitch
    set_cfg(4'd8, 2'd0, 1'b0);
    v0 = valid_cyc;
    bt = 0;
    rx = 1'b0;
    for (int i = 0; i < 44; i++) begin
      wait_tick();
      if (busy) bt++;
      if (i == 3) rx = 1'b1;
    end
    chk("t3_busy_ticks", int'(bt >= 1 && bt <= 9), 1);
    chk("t3_no_valid", valid_cyc - v0, 0);
    idle(1);

    // 8N2 0x3C, second stop bit 0
    set_cfg(4'd8, 2'd0, 1'b1);
    q.push_back('{9'h03C, 1'b0, 1'b1});
    send_frame(9'h03C, 8, -1, 1'b1, 1'b0, 2);
    idle(2);

    // 20-bit break
    q.push_back('{9'h000, 1'b0, 1'b1});
    rx = 1'b0;
    repeat (20 * 16) wait_tick();
    chk("t4_wait_idle_busy", int'(busy), 1);
    rx = 1'b1;
    repeat (4) wait_tick();
    chk("t4_back_to_idle", int'(busy), 0);
    idle(2);

    // Overrun: 0x11 held, 0x22 dropped
    set_cfg(4'd8, 2'd0, 1'b0);
    ready = 1'b0;
    o0 = ovr_cnt;
    q.push_back('{9'h011, 1'b0, 1'b0});
    send_frame(9'h011, 8, -1, 1'b1, 1'b1, 1);
    send_frame(9'h022, 8, -1, 1'b1, 1'b1, 1);
    idle(2);
    chk("t5_held_data", int'(data), 'h011);
    chk("t5_held_valid", int'(valid), 1);
    chk("t5_overrun_pulses", ovr_cnt - o0, 1);
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_valid_drop", int'(valid), 0);
    idle(1);

    // Reset in data bit 3
    fork
      send_frame(9'h0FF, 8, -1, 1'b1, 1'b1, 1);
      begin
        repeat (16 * 4 + 4) wait_tick();
        chk("t6_busy_pre_reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs",
            int'({data, valid, perr, ferr, ovr, busy}), 0);
      end
    join
    idle(2);
    rst_n = 1'b1;
    idle(1);
    q.push_back('{9'h05A, 1'b0, 1'b0});
    send_frame(9'h05A, 8, -1, 1'b1, 1'b1, 1);
    idle(2);

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
